// File: rtl/barcode_line_sampler.sv
// Walks a scan line of RGB pixels, thresholds luma into bar bits and streams them as 32-bit words.
// Optional bar/space transition counter is built only when BARCODE_LINE_SAMPLER_EDGE_COUNT_EN is defined.
module barcode_line_sampler #(
   parameter int PIXEL_W       = 8,
   parameter int NUM_PIXELS    = 256,
   parameter int SEL_W         = 8,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic               clk_clk,
   input  logic               reset_reset,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [SEL_W-1:0]   pixelselect_export,
   input  logic [PIXEL_W-1:0] pixelr_export,
   input  logic [PIXEL_W-1:0] pixelg_export,
   input  logic [PIXEL_W-1:0] pixelb_export,
   input  logic [PIXEL_W-1:0] threshold,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_data,
   output logic [7:0]         out_index,
   output logic [15:0]        edge_count
);

   typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, EMIT, FINISH} state_t;

   localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_PIXELS - 1);
   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   // With no settle time the select change goes straight to sampling.
   localparam state_t           AFTER_SEL   = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

   state_t             state_q;
   logic [3:0]         settle_cnt_q;
   logic [SEL_W-1:0]   sel_q;
   logic [PIXEL_W-1:0] thr_q;
   logic [31:0]        word_q;
   logic [4:0]         bit_cnt_q;
   logic [7:0]         idx_q;
   logic               busy_q;
   logic               done_q;
   logic               valid_q;

   logic [PIXEL_W+1:0] luma_sum;
   logic [PIXEL_W-1:0] luma;
   logic               bar_bit;
   logic               last_pixel;
   logic               word_full;

   // Weighted sum is at most 4*max, so the two extra bits hold it and the shift never overflows.
   assign luma_sum   = {2'b00, pixelr_export} + {1'b0, pixelg_export, 1'b0} + {2'b00, pixelb_export};
   assign luma       = luma_sum[PIXEL_W+1:2];
   assign bar_bit    = (luma < thr_q);
   assign last_pixel = (sel_q == LAST_SEL);
   assign word_full  = (bit_cnt_q == 5'd31);

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q      <= IDLE;
         settle_cnt_q <= '0;
         sel_q        <= '0;
         thr_q        <= '0;
         word_q       <= '0;
         bit_cnt_q    <= '0;
         idx_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         valid_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  thr_q        <= threshold;
                  sel_q        <= '0;
                  word_q       <= '0;
                  bit_cnt_q    <= '0;
                  idx_q        <= '0;
                  settle_cnt_q <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= AFTER_SEL;
               end
            end
            SETTLE: begin
               if (settle_cnt_q == SETTLE_LAST) begin
                  state_q <= SAMPLE;
               end else begin
                  settle_cnt_q <= settle_cnt_q + 4'd1;
               end
            end
            SAMPLE: begin
               word_q[bit_cnt_q] <= bar_bit;
               bit_cnt_q         <= bit_cnt_q + 5'd1;
               settle_cnt_q      <= '0;
               if (word_full || last_pixel) begin
                  valid_q <= 1'b1;
                  state_q <= EMIT;
               end else begin
                  sel_q   <= sel_q + 1'b1;
                  state_q <= AFTER_SEL;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  word_q  <= '0;
                  idx_q   <= idx_q + 8'd1;
                  if (last_pixel) begin
                     done_q  <= 1'b1;
                     state_q <= FINISH;
                  end else begin
                     sel_q   <= sel_q + 1'b1;
                     state_q <= AFTER_SEL;
                  end
               end
            end
            FINISH: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef BARCODE_LINE_SAMPLER_EDGE_COUNT_EN
   logic        prev_bit_q;
   logic [15:0] edge_cnt_q;

   // Pixel 0 has no predecessor in this scan, so it only seeds prev_bit_q.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         prev_bit_q <= 1'b0;
         edge_cnt_q <= '0;
      end else if (state_q == IDLE && start) begin
         edge_cnt_q <= '0;
      end else if (state_q == SAMPLE) begin
         prev_bit_q <= bar_bit;
         if (sel_q != '0 && bar_bit != prev_bit_q && edge_cnt_q != 16'hFFFF) begin
            edge_cnt_q <= edge_cnt_q + 16'd1;
         end
      end
   end

   assign edge_count = edge_cnt_q;
`else
   assign edge_count = 16'd0;
`endif

   assign busy               = busy_q;
   assign done               = done_q;
   assign out_valid          = valid_q;
   assign out_data           = word_q;
   assign out_index          = idx_q;
   assign pixelselect_export = sel_q;

endmodule

// File: tb/tb_barcode_line_sampler.sv
// Randomised bench for barcode_line_sampler: a line-level model predicts every emitted word,
// the transition count and the start-to-done time; one negedge process compares the DUT against it.
module tb_barcode_line_sampler;
   localparam int PW = 8;
   localparam int NP = 40;
   localparam int SW = 8;
   localparam int SC = 2;
   localparam int NW = (NP + 31) / 32;

   logic          clk_clk = 1'b0;
   logic          reset_reset = 1'b1;
   logic          start = 1'b0;
   logic          out_ready = 1'b0;
   logic [PW-1:0] threshold = '0;
   logic          busy, done, out_valid;
   logic [SW-1:0] sel;
   logic [PW-1:0] pix_r, pix_g, pix_b;
   logic [31:0]   out_data;
   logic [7:0]    out_index;
   logic [15:0]   edge_count;

   logic [PW-1:0] mem_r [256];
   logic [PW-1:0] mem_g [256];
   logic [PW-1:0] mem_b [256];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ready_mode = 0;
   int stall_left = 0;

   logic [31:0] exp_w [NW];
   int          exp_edges;

   barcode_line_sampler #(
      .PIXEL_W(PW), .NUM_PIXELS(NP), .SEL_W(SW), .SETTLE_CYCLES(SC)
   ) dut (
      .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start), .busy(busy), .done(done),
      .pixelselect_export(sel), .pixelr_export(pix_r), .pixelg_export(pix_g), .pixelb_export(pix_b),
      .threshold(threshold), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_index(out_index), .edge_count(edge_count)
   );

   assign pix_r = mem_r[sel];
   assign pix_g = mem_g[sel];
   assign pix_b = mem_b[sel];

   always #5 clk_clk = ~clk_clk;
   always @(posedge clk_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference rules: luma, bar bit, packed words, transitions.
   function automatic int luma(input int r, input int g, input int b);
      return (r + 2 * g + b) / 4;
   endfunction

   function automatic logic bar_of(input int k, input int thr);
      return luma(mem_r[k], mem_g[k], mem_b[k]) < thr;
   endfunction

   function automatic logic [31:0] word_of(input int w, input int thr);
      logic [31:0] v = '0;
      for (int k = 0; k < 32; k++)
         if (w * 32 + k < NP) v[k] = bar_of(w * 32 + k, thr);
      return v;
   endfunction

   function automatic int edges_of(input int thr);
      int e = 0;
      for (int k = 1; k < NP; k++)
         if (bar_of(k, thr) != bar_of(k - 1, thr)) e++;
      return e;
   endfunction

   task automatic fill(input int kind);
      for (int k = 0; k < 256; k++) begin
         case (kind)
            0: begin mem_r[k] = 0; mem_g[k] = 0; mem_b[k] = 0; end
            1: begin mem_r[k] = (k % 2) ? 200 : 10; mem_g[k] = mem_r[k]; mem_b[k] = mem_r[k]; end
            2: begin mem_r[k] = 255; mem_g[k] = 255; mem_b[k] = 255; end
            3: begin mem_r[k] = 0; mem_g[k] = 255; mem_b[k] = 0; end
            default: begin
               mem_r[k] = PW'($urandom_range(0, 255));
               mem_g[k] = PW'($urandom_range(0, 255));
               mem_b[k] = PW'($urandom_range(0, 255));
            end
         endcase
      end
   endtask

   // Ready driver: always ready, random, or ten stall cycles on the first emitted word.
   initial forever begin
      @(posedge clk_clk);
      #1;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'($urandom_range(0, 1));
         default: begin
            out_ready = !(out_valid && stall_left > 0);
            if (!out_ready) stall_left--;
         end
      endcase
   end

   // Compare process.
   initial begin : compare
      bit         active = 0;
      int         start_cyc = 0, exp_idx = 0, stalls = 0, thr_lat = 0;
      bit         prev_stalled = 0;
      logic [7:0] prev_sel = '0;
      forever begin
         @(negedge clk_clk);
         if (reset_reset) begin
            active = 0;
            prev_stalled = 0;
         end else if (!active && start && !busy) begin
            active = 1;
            start_cyc = cyc;
            thr_lat = threshold;
            exp_idx = 0;
            stalls = 0;
            prev_stalled = 0;
            for (int w = 0; w < NW; w++) exp_w[w] = word_of(w, thr_lat);
`ifdef BARCODE_LINE_SAMPLER_EDGE_COUNT_EN
            exp_edges = edges_of(thr_lat);
`else
            exp_edges = 0;
`endif
         end else if (active) begin
            check("sel_range", 32'(sel > SW'(NP - 1)), 0);
            if (out_valid) begin
               if (prev_stalled) check("sel_frozen", sel, prev_sel);
               check("out_index", out_index, exp_idx);
               if (exp_idx < NW) check("out_data", out_data, exp_w[exp_idx]);
               else check("extra_word", 1, 0);
               if (out_ready) exp_idx++;
               else stalls++;
            end
            prev_stalled = out_valid && !out_ready;
            prev_sel = sel;
            if (done) begin
               check("done_latency", cyc - start_cyc, NP * (SC + 1) + NW + 1 + stalls);
               check("words_sent", exp_idx, NW);
               check("final_index", out_index, NW);
               check("edge_count", edge_count, exp_edges);
               $display("scan done: thr=%0d words=%0d stalls=%0d edges=%0d", thr_lat, exp_idx, stalls, edge_count);
               active = 0;
            end else begin
               check("busy_high", busy, 1);
            end
         end else begin
            check("idle_done", done, 0);
            check("idle_valid", out_valid, 0);
            check("idle_busy", busy, 0);
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk_clk);
      #1 start = 1'b1;
      @(posedge clk_clk);
      #1 start = 1'b0;
   endtask

   task automatic run_scan(input int mode, input int thr_v, input bit poke);
      int t;
      ready_mode = mode;
      stall_left = 10;
      threshold  = PW'(thr_v);
      pulse_start();
      for (t = 0; t < 3000; t++) begin
         @(negedge clk_clk);
         if (done) break;
         if (poke && t == 50) begin #1; start = 1'b1; threshold = ~threshold; end
         if (poke && t == 51) begin #1; start = 1'b0; end
      end
      if (t >= 3000) check("scan_timeout", 0, 1);
      repeat (3) @(posedge clk_clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_index"}, out_index, 0);
      check({tag, "_sel"}, sel, 0);
      check({tag, "_edges"}, edge_count, 0);
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int t;
      fill(0);
      #2;
      check_reset_outputs("reset");
      repeat (3) @(posedge clk_clk);
      #1 reset_reset = 1'b0;

      // Pin the model against hand-computed values.
      check("pin_zero_w0", word_of(0, 128), 32'hFFFFFFFF);
      check("pin_zero_w1", word_of(1, 128), 32'h000000FF);
      check("pin_luma_white", luma(255, 255, 255), 255);
      check("pin_luma_green", luma(0, 255, 0), 127);
      run_scan(0, 128, 0);

      fill(1);
      check("pin_alt_w0", word_of(0, 128), 32'h55555555);
      check("pin_alt_w1", word_of(1, 128), 32'h00000055);
      check("pin_alt_edges", edges_of(128), 39);
      run_scan(0, 128, 0);

      fill(2);
      check("pin_white_w0", word_of(0, 255), 32'h0);
      run_scan(0, 255, 0);

      fill(3);
      run_scan(0, 128, 0);
      run_scan(1, 127, 0);

      fill(4);
      run_scan(2, $urandom_range(0, 255), 0);
      fill(4);
      run_scan(1, $urandom_range(0, 255), 1);

      // Asynchronous reset in the middle of pixel 17.
      fill(4);
      ready_mode = 0;
      threshold = PW'($urandom_range(0, 255));
      pulse_start();
      for (t = 0; t < 500; t++) begin
         @(negedge clk_clk);
         if (sel == 8'd17) break;
      end
      if (t >= 500) check("reach_pixel17", 0, 1);
      #2 reset_reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      repeat (2) @(posedge clk_clk);
      #1 reset_reset = 1'b0;
      repeat (40) @(posedge clk_clk);

      for (int s = 0; s < 5; s++) begin
         fill(4);
         run_scan($urandom_range(0, 1), $urandom_range(0, 255), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/barcode_line_sampler.md
BARCODE_LINE_SAMPLER -- requirements
Module: barcode_line_sampler

Interface
REQ-001 SHALL have parameter PIXEL_W, default 8, bits per colour channel.
REQ-002 SHALL have parameter NUM_PIXELS, default 256, pixels per scan line (1..2**SEL_W).
REQ-003 SHALL have parameter SEL_W, default 8, pixel-select index width.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 2, wait cycles after a select change before sampling (0..15).
REQ-005 SHALL have ports: clk_clk in 1 (sole clock); reset_reset in 1 (asynchronous, active-high reset).
REQ-006 SHALL have ports: start in 1 (scan request pulse); busy out 1; done out 1 (one-cycle pulse at scan end).
REQ-007 SHALL have ports: pixelselect_export out SEL_W (pixel index to external source); pixelr_export, pixelg_export, pixelb_export in PIXEL_W each.
REQ-008 SHALL have ports: threshold in PIXEL_W (dark/light boundary, sampled at start).
REQ-009 SHALL have ports: out_valid out 1; out_ready in 1; out_data out 32 (packed bar bits); out_index out 8 (word number).
REQ-010 SHALL have port edge_count out 16 (bar/space transition count, see Configuration).

Function
REQ-011 SHALL implement FSM states IDLE, SETTLE, SAMPLE, EMIT, FINISH.
REQ-012 IDLE: start=1 SHALL latch threshold, clear pixel counter, word buffer, bit counter, out_index, edge_count; drive pixelselect_export=0; go SETTLE; busy=1 next cycle.
REQ-013 start while busy=1 SHALL be ignored.
REQ-014 SETTLE SHALL wait exactly SETTLE_CYCLES cycles (0 = skip directly to SAMPLE) with pixelselect_export held.
REQ-015 SAMPLE (one cycle) SHALL compute luma = (R + 2*G + B) >> 2 at PIXEL_W+2 bits internally, truncated to PIXEL_W without overflow.
REQ-016 Bar bit SHALL be 1 when luma < latched threshold, else 0.
REQ-017 Bits SHALL pack LSB-first: pixel k of the line goes to out_data bit (k mod 32) of word k/32.
REQ-018 After SAMPLE, when 32 bits are collected or the pixel was the last (index NUM_PIXELS-1), SHALL go EMIT; else increment pixelselect_export and go SETTLE.
REQ-019 Partial final word SHALL have unused upper bits zero.
REQ-020 EMIT SHALL hold out_valid=1 with stable out_data/out_index until out_ready=1; transfer occurs on the cycle both are 1.
REQ-021 After transfer: out_valid=0 next cycle, out_index increments, buffer clears; if the line is done go FINISH, else increment pixelselect_export and go SETTLE.
REQ-022 out_ready asserted before out_valid SHALL have no effect; out_valid SHALL never drop without a transfer.
REQ-023 FINISH SHALL pulse done=1 for one cycle, deassert busy, and return to IDLE; edge_count and the last out_index remain valid until the next start.
REQ-024 Per-pixel latency (no stall) SHALL be SETTLE_CYCLES+1 cycles; total scan time = NUM_PIXELS*(SETTLE_CYCLES+1) + ceil(NUM_PIXELS/32) + 1 cycles, from start to done, with out_ready held 1.
REQ-025 pixelselect_export SHALL never exceed NUM_PIXELS-1 and SHALL NOT wrap during a scan.

Reset
REQ-026 reset_reset=1 SHALL immediately force IDLE, busy=0, done=0, out_valid=0, out_data=0, out_index=0, pixelselect_export=0, edge_count=0, regardless of clock.
REQ-027 Reset mid-scan or mid-EMIT SHALL abandon the scan with no further output; the next start begins a full new scan.

Configuration
REQ-028 Macro BARCODE_LINE_SAMPLER_EDGE_COUNT_EN defined: edge_count SHALL increment (saturating at 65535) whenever a sampled bar bit differs from the previous pixel's bit within the same scan (pixel 0 never counts).
REQ-029 Macro undefined: edge_count SHALL be tied to 0 and no transition logic SHALL be synthesised.

Verification
REQ-030 NUM_PIXELS=64, SETTLE_CYCLES=2, threshold=128, all pixels R=G=B=0, out_ready=1 -> two words 0xFFFFFFFF at out_index 0,1; done at cycle 64*3+2+1=195 after start.
REQ-031 NUM_PIXELS=40, pixels alternate luma 10/200 starting dark -> word0=0x55555555, word1=0x00000055 (upper 24 bits zero); edge_count=39 with macro, 0 without.
REQ-032 R=255,G=255,B=255 -> luma=255, no overflow; threshold=255 gives bit 0; R=0,G=255,B=0 -> luma=127.
REQ-033 out_ready held 0 for 10 cycles during EMIT of word0 -> out_valid and out_data stable all 10 cycles, pixelselect_export frozen, single transfer on release.
REQ-034 start pulsed again while busy -> ignored, scan output unchanged; reset_reset asserted at pixel 17 -> all outputs to reset values same cycle, no done pulse.
